// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the inst/data bus arbiter: source IDs and FSM states.
package mem_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_id_t;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_t;

  localparam logic [2:0] INST_SIZE = 3'd2;

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// In-order FIFO of 1-bit source IDs for transactions awaiting a bus response.
module id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_push,
  input  logic i_push_id,
  input  logic i_pop,
  output logic o_head_id,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_head_id = r_mem[r_rptr];
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_id;
        r_wptr        <= nxt(r_wptr);
      end
      if (w_pop) r_rptr <= nxt(r_rptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (inst/data) arbiter onto one pipelined bus with in-order responses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [2:0]  bus_size,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t r_state, w_next;
  src_id_t    w_gnt;
  logic       w_gnt_vld, w_hs, w_pop;
  logic       w_full, w_empty, w_head;
  logic [SW-1:0] r_starve;

  // A stalled grant is held in HOLD_x so the bus sees a stable request.
  always_comb begin
    w_next    = r_state;
    w_gnt     = SRC_DATA;
    w_gnt_vld = 1'b0;
    case (r_state)
      ARB: if (!w_full) begin
        if (inst_req && (r_starve == SW'(STARVE_MAX) || !data_req)) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SRC_INST;
        end else if (data_req) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SRC_DATA;
        end
      end
      HOLD_I: begin
        w_gnt_vld = 1'b1;
        w_gnt     = SRC_INST;
      end
      HOLD_D: begin
        w_gnt_vld = 1'b1;
        w_gnt     = SRC_DATA;
      end
      default: w_next = ARB;
    endcase
    if (!resetn) w_gnt_vld = 1'b0;
    if (w_gnt_vld) begin
      if (bus_addr_ok)       w_next = ARB;
      else if (r_state == ARB) w_next = (w_gnt == SRC_INST) ? HOLD_I : HOLD_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ARB;
    else         r_state <= w_next;
  end

  assign w_hs         = w_gnt_vld & bus_addr_ok;
  assign inst_addr_ok = w_hs & (w_gnt == SRC_INST);
  assign data_addr_ok = w_hs & (w_gnt == SRC_DATA);

  always_comb begin
    bus_req = w_gnt_vld;
    if (w_gnt == SRC_INST) begin
      bus_wr    = 1'b0;
      bus_wstrb = '0;
      bus_addr  = inst_addr;
      bus_size  = INST_SIZE;
      bus_wdata = '0;
    end else begin
      bus_wr    = data_wr;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_size  = data_size;
      bus_wdata = data_wdata;
    end
  end

  // Counts data wins while inst is waiting; inst wins once it saturates.
  always_ff @(posedge clk) begin
    if (!resetn)                      r_starve <= '0;
    else if (!inst_req || inst_addr_ok) r_starve <= '0;
    else if (data_addr_ok && r_starve != SW'(STARVE_MAX))
      r_starve <= r_starve + 1'b1;
  end

  id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_hs),
    .i_push_id (w_gnt),
    .i_pop     (w_pop),
    .o_head_id (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_pop        = bus_data_ok & ~w_empty & resetn;
  assign inst_data_ok = w_pop & (src_id_t'(w_head) == SRC_INST);
  assign data_data_ok = w_pop & (src_id_t'(w_head) == SRC_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 OUTSTANDING  2  maximum accepted-but-unanswered bus transactions (1..4)
 STARVE_MAX  4  consecutive data grants allowed while inst waits
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  input  1  sole clock, rising edge
 resetn  input  1  synchronous reset, active low
 inst_req  input  1  fetch request
 inst_addr  input  32  fetch address
 inst_rdata  output  32  fetch read data
 inst_addr_ok  output  1  fetch address accepted
 inst_data_ok  output  1  fetch data returned
 data_req  input  1  load/store request
 data_wr  input  1  1 = store
 data_wstrb  input  4  store byte strobes
 data_addr  input  32  load/store address
 data_size  input  3  access size
 data_wdata  input  32  store data
 data_rdata  output  32  load read data
 data_addr_ok  output  1  load/store address accepted
 data_data_ok  output  1  load/store response returned
 bus_req  output  1  shared bus request
 bus_wr  output  1  shared bus write
 bus_wstrb  output  4  shared bus strobes
 bus_addr  output  32  shared bus address
 bus_size  output  3  shared bus size
 bus_wdata  output  32  shared bus write data
 bus_rdata  input  32  shared bus read data
 bus_addr_ok  input  1  shared bus address accepted
 bus_data_ok  input  1  shared bus response, in issue order
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-low on resetn.

Function
REQ-004 The arbiter SHALL grant one requester per cycle to the bus; bus_* request fields SHALL equal the granted requester's fields; an inst grant SHALL drive bus_wr=0, bus_wstrb=0, bus_size=2.
REQ-005 Arbitration SHALL give data priority, except inst SHALL win when the starvation counter equals STARVE_MAX.
REQ-006 The starvation counter SHALL increment on each data address handshake while inst_req=1, clear on an inst handshake or when inst_req=0, and saturate at STARVE_MAX.
REQ-007 The FSM SHALL have states ARB, HOLD_I, HOLD_D; ARB->HOLD_x when bus_req=1 and bus_addr_ok=0 for grant x; HOLD_x->ARB on bus_addr_ok; in HOLD_x the grant and bus_* fields SHALL stay frozen regardless of the other requester.
REQ-008 The granted requester's addr_ok SHALL be bus_addr_ok combinationally; the non-granted addr_ok SHALL be 0.
REQ-009 Each address handshake SHALL push the source ID (0 inst, 1 data) into an in-order FIFO of depth OUTSTANDING.
REQ-010 When the FIFO is full, bus_req SHALL be 0 and no grant is made, even if bus_data_ok pops in the same cycle.
REQ-011 bus_data_ok SHALL pop the FIFO head and assert exactly that source's data_ok in the same cycle; inst_rdata and data_rdata SHALL both equal bus_rdata.
REQ-012 Simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged with correct ordering.
REQ-013 bus_data_ok with the FIFO empty SHALL be ignored: neither data_ok asserted.
REQ-014 No input SHALL be registered in the request path; latency from req to bus_req SHALL be 0 cycles.

Reset
REQ-015 While resetn=0, the FSM SHALL enter ARB, the FIFO and starvation counter SHALL clear, and bus_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL be 0.
REQ-016 Responses arriving after a mid-transaction reset SHALL be discarded under REQ-013.

Structure
REQ-017 Source-ID encodings and FSM state encodings SHALL live in the shared common header.
REQ-018 The ID FIFO SHALL be one sub-module, id_fifo (parameterised depth, 1-bit payload, full/empty flags).

Verification
REQ-019 Both requesters assert at once, bus_addr_ok=1 -> data granted first, then inst the next cycle; data_data_ok precedes inst_data_ok.
REQ-020 data_req held high with inst_req high, STARVE_MAX=4 -> 4 data handshakes, then 1 inst handshake.
REQ-021 Inst granted, bus_addr_ok=0 for 3 cycles while data_req rises -> bus_addr equals inst_addr throughout; inst_addr_ok is pulsed on cycle 4.
REQ-022 OUTSTANDING=2, two handshakes with no response -> bus_req=0; a single bus_data_ok then re-enables bus_req on the next cycle.
REQ-023 bus_data_ok with the FIFO empty, bus_rdata=0xDEADBEEF -> inst_data_ok=0 and data_data_ok=0.
REQ-024 resetn pulsed low with 2 outstanding transactions, then 2 bus_data_ok -> no data_ok asserted; FIFO stays empty.
